// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid storage,
// flush-to-NOP, stall freeze and a saturating count of flushed entries.
module pipe_stage_skid_reg #(
    parameter int unsigned     INS_W   = 32,
    parameter int unsigned     PC_W    = 32,
    parameter int unsigned     VEC_W   = 5,
    parameter logic [INS_W-1:0] NOP_INS = '0,
    parameter int unsigned     CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] in_ins,
    input  logic [PC_W-1:0]  in_pc4,
    input  logic [VEC_W-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] out_ins,
    output logic [PC_W-1:0]  out_pc4,
    output logic [VEC_W-1:0] out_vec,
    input  logic             flush,
    input  logic             stall,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [INS_W-1:0]   head_ins_q, head_ins_d;
    logic [PC_W-1:0]    head_pc4_q, head_pc4_d;
    logic [VEC_W-1:0]   head_vec_q, head_vec_d;
    logic [INS_W-1:0]   skid_ins_q, skid_ins_d;
    logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;
    logic [VEC_W-1:0]   skid_vec_q, skid_vec_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [SUM_W-1:0]   drop_sum;
    logic               acc, emit;

    assign out_ins  = head_ins_q;
    assign out_pc4  = head_pc4_q;
    assign out_vec  = head_vec_q;
    assign drop_cnt = drop_cnt_q;

    // Handshake gating; depends only on state and control inputs, never on out_ready
    always_comb begin
        in_ready  = (state_q != FULL)  && !flush && !stall && !reset;
        out_valid = (state_q != EMPTY) && !flush && !stall && !reset;
        acc       = in_valid && in_ready;
        emit      = out_valid && out_ready;
    end

    always_comb begin
        case (state_q)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Flushed entries are added with saturation at all-ones
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q} + SUM_W'(occupancy);
    end

    always_comb begin
        state_d    = state_q;
        head_ins_d = head_ins_q;
        head_pc4_d = head_pc4_q;
        head_vec_d = head_vec_q;
        skid_ins_d = skid_ins_q;
        skid_pc4_d = skid_pc4_q;
        skid_vec_d = skid_vec_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            state_d    = EMPTY;
            head_ins_d = NOP_INS;
            head_pc4_d = '0;
            head_vec_d = '0;
            skid_ins_d = '0;
            skid_pc4_d = '0;
            skid_vec_d = '0;
            drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else if (!stall) begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d    = ONE;
                        head_ins_d = in_ins;
                        head_pc4_d = in_pc4;
                        head_vec_d = in_vec;
                    end
                end
                ONE: begin
                    if (acc && emit) begin
                        head_ins_d = in_ins;
                        head_pc4_d = in_pc4;
                        head_vec_d = in_vec;
                    end else if (acc) begin
                        state_d    = FULL;
                        skid_ins_d = in_ins;
                        skid_pc4_d = in_pc4;
                        skid_vec_d = in_vec;
                    end else if (emit) begin
                        state_d    = EMPTY;
                        head_ins_d = NOP_INS;
                        head_pc4_d = '0;
                        head_vec_d = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the head can move
                    if (emit) begin
                        state_d    = ONE;
                        head_ins_d = skid_ins_q;
                        head_pc4_d = skid_pc4_q;
                        head_vec_d = skid_vec_q;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    head_ins_d = NOP_INS;
                    head_pc4_d = '0;
                    head_vec_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            head_ins_q <= NOP_INS;
            head_pc4_q <= '0;
            head_vec_q <= '0;
            skid_ins_q <= '0;
            skid_pc4_q <= '0;
            skid_vec_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            head_ins_q <= head_ins_d;
            head_pc4_q <= head_pc4_d;
            head_vec_q <= head_vec_d;
            skid_ins_q <= skid_ins_d;
            skid_pc4_q <= skid_pc4_d;
            skid_vec_q <= skid_vec_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
